// File: rtl/resv_station_gen_if.sv
// rtl/resv_station_gen_if.sv - dispatch, broadcast and issue bus of the reservation station
//
// Groups the three streams that cross the station boundary:
//   dispatch  DFI_valid/DFO_ready + DFI_* payload  (decode/rename -> station)
//   broadcast CDI_valid/CDI_PA_tag/CDI_PD_data     (N_CDB result channels, channel k
//             at [k*W_REG +: W_REG] / [k*W_DATA +: W_DATA])
//   issue     DFO_valid/DFI_ready + DFO_* payload  (station -> execution pipe)
// master: the environment side (decode, CDB, execution pipe); slave: the station.
interface resv_station_gen_if #(
    parameter int N_CDB  = 2,
    parameter int W_REG  = 5,
    parameter int W_DATA = 32,
    parameter int W_UOPS = 6,
    parameter int W_PC   = 32
);
    logic                    DFI_valid;
    logic                    DFO_ready;
    logic [W_UOPS-1:0]       DFI_PD_uops;
    logic [W_REG-1:0]        DFI_PA_rd;
    logic [W_REG-1:0]        DFI_PA_rs;
    logic [W_REG-1:0]        DFI_PA_rt;
    logic                    DFI_PV_rs;
    logic                    DFI_PV_rt;
    logic [W_DATA-1:0]       DFI_PD_rs;
    logic [W_DATA-1:0]       DFI_PD_rt;
    logic [W_DATA-1:0]       DFI_PD_imm;
    logic [W_PC-1:0]         DFI_AA_pc;

    logic [N_CDB-1:0]        CDI_valid;
    logic [N_CDB*W_REG-1:0]  CDI_PA_tag;
    logic [N_CDB*W_DATA-1:0] CDI_PD_data;

    logic                    DFO_valid;
    logic                    DFI_ready;
    logic [W_UOPS-1:0]       DFO_PD_uops;
    logic [W_REG-1:0]        DFO_PA_rd;
    logic [W_DATA-1:0]       DFO_PD_rs;
    logic [W_DATA-1:0]       DFO_PD_rt;
    logic [W_DATA-1:0]       DFO_PD_imm;
    logic [W_PC-1:0]         DFO_AA_pc;

    modport master (
        output DFI_valid, DFI_PD_uops, DFI_PA_rd, DFI_PA_rs, DFI_PA_rt,
               DFI_PV_rs, DFI_PV_rt, DFI_PD_rs, DFI_PD_rt, DFI_PD_imm, DFI_AA_pc,
               CDI_valid, CDI_PA_tag, CDI_PD_data, DFI_ready,
        input  DFO_ready, DFO_valid, DFO_PD_uops, DFO_PA_rd, DFO_PD_rs, DFO_PD_rt,
               DFO_PD_imm, DFO_AA_pc
    );

    modport slave (
        input  DFI_valid, DFI_PD_uops, DFI_PA_rd, DFI_PA_rs, DFI_PA_rt,
               DFI_PV_rs, DFI_PV_rt, DFI_PD_rs, DFI_PD_rt, DFI_PD_imm, DFI_AA_pc,
               CDI_valid, CDI_PA_tag, CDI_PD_data, DFI_ready,
        output DFO_ready, DFO_valid, DFO_PD_uops, DFO_PA_rd, DFO_PD_rs, DFO_PD_rt,
               DFO_PD_imm, DFO_AA_pc
    );
endinterface

// File: rtl/resv_station_gen.sv
// rtl/resv_station_gen.sv - age-ordered collapsing reservation station, N_CDB wakeup channels
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   CFI_PC_clear    synchronous flush of all entries (perf counters kept)
//   CFI_PC_stall    inhibit issue this cycle
//   CFO_PC_count    occupied entries
//   CFO_PC_full     count == DEPTH
//   CFO_PD_occ_acc  saturating sum of count per cycle       (RESV_PERF_EN only)
//   CFO_PD_full_cyc saturating count of dispatch-while-full (RESV_PERF_EN only)
//   bus             resv_station_gen_if.slave: dispatch, broadcast and issue streams
// Optional feature macro: RESV_PERF_EN adds the W_PERF parameter and the perf counters.
module resv_station_gen #(
    parameter int DEPTH  = 8,
    parameter int W_IDX  = 3,
    parameter int N_CDB  = 2,
    parameter int W_REG  = 5,
    parameter int W_DATA = 32,
    parameter int W_UOPS = 6,
    parameter int W_PC   = 32
`ifdef RESV_PERF_EN
    ,
    parameter int W_PERF = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CFI_PC_clear,
    input  logic               CFI_PC_stall,
    output logic [W_IDX:0]     CFO_PC_count,
    output logic               CFO_PC_full,
`ifdef RESV_PERF_EN
    output logic [W_PERF-1:0]  CFO_PD_occ_acc,
    output logic [W_PERF-1:0]  CFO_PD_full_cyc,
`endif
    resv_station_gen_if.slave  bus
);
    localparam int WC = W_IDX + 1;

    typedef struct packed {
        logic              v;
        logic [W_DATA-1:0] d;
    } opnd_t;

    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [W_UOPS-1:0] uops_q  [DEPTH];
    logic [W_UOPS-1:0] uops_d  [DEPTH];
    logic [W_REG-1:0]  rd_q    [DEPTH];
    logic [W_REG-1:0]  rd_d    [DEPTH];
    logic              rs_v_q  [DEPTH];
    logic              rs_v_d  [DEPTH];
    logic [W_REG-1:0]  rs_a_q  [DEPTH];
    logic [W_REG-1:0]  rs_a_d  [DEPTH];
    logic [W_DATA-1:0] rs_d_q  [DEPTH];
    logic [W_DATA-1:0] rs_d_d  [DEPTH];
    logic              rt_v_q  [DEPTH];
    logic              rt_v_d  [DEPTH];
    logic [W_REG-1:0]  rt_a_q  [DEPTH];
    logic [W_REG-1:0]  rt_a_d  [DEPTH];
    logic [W_DATA-1:0] rt_d_q  [DEPTH];
    logic [W_DATA-1:0] rt_d_d  [DEPTH];
    logic [W_DATA-1:0] imm_q   [DEPTH];
    logic [W_DATA-1:0] imm_d   [DEPTH];
    logic [W_PC-1:0]   pc_q    [DEPTH];
    logic [W_PC-1:0]   pc_d    [DEPTH];
    logic [W_IDX:0]    count_q;
    logic [W_IDX:0]    count_d;

    logic [N_CDB-1:0]        cdi_valid;
    logic [N_CDB*W_REG-1:0]  cdi_tag;
    logic [N_CDB*W_DATA-1:0] cdi_data;

    logic              has_cand;
    logic [W_IDX-1:0]  sel_idx;
    logic              dfo_valid;
    logic              dfo_ready;
    logic              issue;
    logic              disp;
    int                wr_idx;
    logic              shift;
    logic [W_IDX-1:0]  s;
    opnd_t             rs_w;
    opnd_t             rt_w;

    assign cdi_valid = bus.CDI_valid;
    assign cdi_tag   = bus.CDI_PA_tag;
    assign cdi_data  = bus.CDI_PD_data;

    // Operand capture from the broadcast channels; scanning high to low lets the
    // lowest matching channel overwrite any higher one.
    function automatic opnd_t wake(input logic v, input logic [W_REG-1:0] a,
                                   input logic [W_DATA-1:0] d);
        opnd_t r;
        r.v = v;
        r.d = d;
        if (!v) begin
            for (int k = N_CDB - 1; k >= 0; k--) begin
                if (cdi_valid[k] && (cdi_tag[k*W_REG +: W_REG] == a)) begin
                    r.v = 1'b1;
                    r.d = cdi_data[k*W_DATA +: W_DATA];
                end
            end
        end
        return r;
    endfunction

    // Oldest ready entry, from registered state only (no wakeup bypass into select).
    always_comb begin
        has_cand = 1'b0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rs_v_q[i] && rt_v_q[i]) begin
                has_cand = 1'b1;
                sel_idx  = W_IDX'(i);
            end
        end
    end

    assign dfo_ready    = int'(count_q) < DEPTH;
    assign dfo_valid    = has_cand && !CFI_PC_stall && !CFI_PC_clear;
    assign issue        = dfo_valid && bus.DFI_ready;
    assign disp         = bus.DFI_valid && dfo_ready;
    assign CFO_PC_count = count_q;
    assign CFO_PC_full  = int'(count_q) == DEPTH;
    assign bus.DFO_ready = dfo_ready;
    assign bus.DFO_valid = dfo_valid;

    always_comb begin
        bus.DFO_PD_uops = '1;
        bus.DFO_PA_rd   = '0;
        bus.DFO_PD_rs   = '0;
        bus.DFO_PD_rt   = '0;
        bus.DFO_PD_imm  = '0;
        bus.DFO_AA_pc   = '0;
        if (has_cand) begin
            bus.DFO_PD_uops = uops_q[sel_idx];
            bus.DFO_PA_rd   = rd_q[sel_idx];
            bus.DFO_PD_rs   = rs_d_q[sel_idx];
            bus.DFO_PD_rt   = rt_d_q[sel_idx];
            bus.DFO_PD_imm  = imm_q[sel_idx];
            bus.DFO_AA_pc   = pc_q[sel_idx];
        end
    end

    // Next state: collapse above the issued slot, wake every surviving copy, then
    // drop the dispatched op into the first free slot after the collapse.
    always_comb begin
        valid_d = valid_q;
        uops_d  = uops_q;
        rd_d    = rd_q;
        rs_v_d  = rs_v_q;
        rs_a_d  = rs_a_q;
        rs_d_d  = rs_d_q;
        rt_v_d  = rt_v_q;
        rt_a_d  = rt_a_q;
        rt_d_d  = rt_d_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        shift   = 1'b0;
        s       = '0;
        rs_w    = '0;
        rt_w    = '0;
        wr_idx  = int'(count_q) - (issue ? 1 : 0);
        count_d = count_q + WC'(disp) - WC'(issue);

        for (int i = 0; i < DEPTH; i++) begin
            shift = issue && (i >= int'(sel_idx));
            if (shift && (i == DEPTH - 1)) begin
                valid_d[i] = 1'b0;
            end else begin
                s          = shift ? W_IDX'(i + 1) : W_IDX'(i);
                rs_w       = wake(rs_v_q[s], rs_a_q[s], rs_d_q[s]);
                rt_w       = wake(rt_v_q[s], rt_a_q[s], rt_d_q[s]);
                valid_d[i] = valid_q[s];
                uops_d[i]  = uops_q[s];
                rd_d[i]    = rd_q[s];
                rs_v_d[i]  = rs_w.v;
                rs_a_d[i]  = rs_a_q[s];
                rs_d_d[i]  = rs_w.d;
                rt_v_d[i]  = rt_w.v;
                rt_a_d[i]  = rt_a_q[s];
                rt_d_d[i]  = rt_w.d;
                imm_d[i]   = imm_q[s];
                pc_d[i]    = pc_q[s];
            end
            if (disp && (i == wr_idx)) begin
                rs_w       = wake(bus.DFI_PV_rs, bus.DFI_PA_rs, bus.DFI_PD_rs);
                rt_w       = wake(bus.DFI_PV_rt, bus.DFI_PA_rt, bus.DFI_PD_rt);
                valid_d[i] = 1'b1;
                uops_d[i]  = bus.DFI_PD_uops;
                rd_d[i]    = bus.DFI_PA_rd;
                rs_v_d[i]  = rs_w.v;
                rs_a_d[i]  = bus.DFI_PA_rs;
                rs_d_d[i]  = rs_w.d;
                rt_v_d[i]  = rt_w.v;
                rt_a_d[i]  = bus.DFI_PA_rt;
                rt_d_d[i]  = rt_w.d;
                imm_d[i]   = bus.DFI_PD_imm;
                pc_d[i]    = bus.DFI_AA_pc;
            end
        end

        // Flush discards everything computed above for this cycle.
        if (CFI_PC_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload is only meaningful under valid, so it needs no reset.
    always_ff @(posedge clk) begin
        uops_q <= uops_d;
        rd_q   <= rd_d;
        rs_v_q <= rs_v_d;
        rs_a_q <= rs_a_d;
        rs_d_q <= rs_d_d;
        rt_v_q <= rt_v_d;
        rt_a_q <= rt_a_d;
        rt_d_q <= rt_d_d;
        imm_q  <= imm_d;
        pc_q   <= pc_d;
    end

`ifdef RESV_PERF_EN
    logic [W_PERF-1:0] occ_acc_q;
    logic [W_PERF-1:0] occ_acc_d;
    logic [W_PERF-1:0] full_cyc_q;
    logic [W_PERF-1:0] full_cyc_d;
    logic [W_PERF:0]   occ_sum;

    always_comb begin
        occ_sum    = {1'b0, occ_acc_q} + (W_PERF + 1)'(count_q);
        occ_acc_d  = occ_sum[W_PERF] ? '1 : occ_sum[W_PERF-1:0];
        full_cyc_d = full_cyc_q;
        if (bus.DFI_valid && CFO_PC_full && (full_cyc_q != '1)) begin
            full_cyc_d = full_cyc_q + W_PERF'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_acc_q  <= '0;
            full_cyc_q <= '0;
        end else begin
            occ_acc_q  <= occ_acc_d;
            full_cyc_q <= full_cyc_d;
        end
    end

    assign CFO_PD_occ_acc  = occ_acc_q;
    assign CFO_PD_full_cyc = full_cyc_q;
`endif
endmodule

// File: tb/tb_resv_station_gen.sv
// tb/tb_resv_station_gen.sv - directed self-checking bench for resv_station_gen
module tb_resv_station_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       stall;
    logic [3:0] count;
    logic       full;
`ifdef RESV_PERF_EN
    logic [15:0] occ;
    logic [15:0] fcyc;
`endif
    int n_total = 0;
    int n_bad   = 0;

    resv_station_gen_if #(.N_CDB(2), .W_REG(5), .W_DATA(32), .W_UOPS(6), .W_PC(32)) bus ();

    resv_station_gen dut (
        .clk             (clk),
        .rst             (rst),
        .CFI_PC_clear    (clear),
        .CFI_PC_stall    (stall),
        .CFO_PC_count    (count),
        .CFO_PC_full     (full),
`ifdef RESV_PERF_EN
        .CFO_PD_occ_acc  (occ),
        .CFO_PD_full_cyc (fcyc),
`endif
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nodisp();
        bus.DFI_valid = 1'b0;
    endtask

    task automatic put(input logic [31:0] pc, input logic rsv, input logic [4:0] rsa);
        bus.DFI_valid   = 1'b1;
        bus.DFI_PD_uops = pc[7:2];
        bus.DFI_PA_rd   = pc[6:2];
        bus.DFI_PV_rs   = rsv;
        bus.DFI_PA_rs   = rsa;
        bus.DFI_PD_rs   = rsv ? pc + 32'h1000 : 32'h0;
        bus.DFI_PV_rt   = 1'b1;
        bus.DFI_PA_rt   = 5'd0;
        bus.DFI_PD_rt   = pc ^ 32'hA5A5_0000;
        bus.DFI_PD_imm  = pc + 32'd7;
        bus.DFI_AA_pc   = pc;
    endtask

    task automatic cdi(input logic [1:0] v, input logic [4:0] t0, input logic [31:0] d0,
                       input logic [4:0] t1, input logic [31:0] d1);
        bus.CDI_valid   = v;
        bus.CDI_PA_tag  = {t1, t0};
        bus.CDI_PD_data = {d1, d0};
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_valid"}, 64'(bus.DFO_valid), 64'd0);
        check({tag, "_ready"}, 64'(bus.DFO_ready), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_uops"}, 64'(bus.DFO_PD_uops), 64'h3f);
        check({tag, "_rd"}, 64'(bus.DFO_PA_rd), 64'd0);
        check({tag, "_rs"}, 64'(bus.DFO_PD_rs), 64'd0);
        check({tag, "_rt"}, 64'(bus.DFO_PD_rt), 64'd0);
        check({tag, "_imm"}, 64'(bus.DFO_PD_imm), 64'd0);
        check({tag, "_pc"}, 64'(bus.DFO_AA_pc), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        stall = 1'b0;
        bus.DFI_ready = 1'b1;
        put(32'h0, 1'b0, 5'd0);
        nodisp();
        cdi(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        step();
        chk_reset_outs("rst0");
        rst = 1'b0;

        // 1: three ready ops issue in order, one per cycle
        put(32'h100, 1'b1, 5'd0);
        #1;
        check("t1_c0_count", 64'(count), 64'd0);
        check("t1_c0_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        put(32'h104, 1'b1, 5'd0);
        #1;
        check("t1_c1_valid", 64'(bus.DFO_valid), 64'd1);
        check("t1_c1_pc", 64'(bus.DFO_AA_pc), 64'h100);
        check("t1_c1_rs", 64'(bus.DFO_PD_rs), 64'h1100);
        check("t1_c1_rt", 64'(bus.DFO_PD_rt), 64'hA5A50100);
        check("t1_c1_imm", 64'(bus.DFO_PD_imm), 64'h107);
        check("t1_c1_count", 64'(count), 64'd1);
        step();
        put(32'h108, 1'b1, 5'd0);
        #1;
        check("t1_c2_pc", 64'(bus.DFO_AA_pc), 64'h104);
        check("t1_c2_uops", 64'(bus.DFO_PD_uops), 64'h1);
        check("t1_c2_count", 64'(count), 64'd1);
        step();
        nodisp();
        #1;
        check("t1_c3_pc", 64'(bus.DFO_AA_pc), 64'h108);
        check("t1_c3_rd", 64'(bus.DFO_PA_rd), 64'h2);
        check("t1_c3_count", 64'(count), 64'd1);
        step();
        check("t1_c4_count", 64'(count), 64'd0);
        check("t1_c4_valid", 64'(bus.DFO_valid), 64'd0);
        check("t1_c4_uops", 64'(bus.DFO_PD_uops), 64'h3f);

        // 2: wakeup on channel 1, selectable the cycle after the broadcast
        put(32'h200, 1'b0, 5'd5);
        step();
        nodisp();
        cdi(2'b10, 5'd3, 32'h11, 5'd5, 32'hDEADBEEF);
        #1;
        check("t2_bcast_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        cdi(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("t2_valid", 64'(bus.DFO_valid), 64'd1);
        check("t2_rs", 64'(bus.DFO_PD_rs), 64'hDEADBEEF);
        check("t2_pc", 64'(bus.DFO_AA_pc), 64'h200);
        step();
        check("t2_count", 64'(count), 64'd0);

        // 3: fill, reject while full, wake entry 3, check the collapse
        for (int i = 0; i < 8; i++) begin
            put(32'h300 + 32'(4 * i), 1'b0, 5'(8 + i));
            step();
        end
        put(32'h3F0, 1'b1, 5'd0);
        #1;
        check("t3_full_count", 64'(count), 64'd8);
        check("t3_full", 64'(full), 64'd1);
        check("t3_full_ready", 64'(bus.DFO_ready), 64'd0);
        check("t3_full_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        nodisp();
        cdi(2'b01, 5'd11, 32'h33, 5'd0, 32'h0);
        #1;
        check("t3_reject_count", 64'(count), 64'd8);
        step();
        cdi(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("t3_e3_valid", 64'(bus.DFO_valid), 64'd1);
        check("t3_e3_pc", 64'(bus.DFO_AA_pc), 64'h30C);
        check("t3_e3_rs", 64'(bus.DFO_PD_rs), 64'h33);
        step();
        cdi(2'b11, 5'd12, 32'h44, 5'd15, 32'h77);
        #1;
        check("t3_after_count", 64'(count), 64'd7);
        check("t3_after_full", 64'(full), 64'd0);
        check("t3_after_ready", 64'(bus.DFO_ready), 64'd1);
        check("t3_after_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        cdi(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("t3_shift4_pc", 64'(bus.DFO_AA_pc), 64'h310);
        check("t3_shift4_rs", 64'(bus.DFO_PD_rs), 64'h44);
        step();
        check("t3_shift7_pc", 64'(bus.DFO_AA_pc), 64'h31C);
        check("t3_shift7_rs", 64'(bus.DFO_PD_rs), 64'h77);
        check("t3_shift7_count", 64'(count), 64'd6);
        step();
        check("t3_end_count", 64'(count), 64'd5);
        check("t3_end_valid", 64'(bus.DFO_valid), 64'd0);

        // 4: same-cycle dispatch+broadcast, both channels match, channel 0 wins
        put(32'h400, 1'b0, 5'd7);
        cdi(2'b11, 5'd7, 32'h55, 5'd7, 32'h66);
        #1;
        check("t4_same_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        nodisp();
        cdi(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.DFI_ready = 1'b0;
        #1;
        check("t4_valid", 64'(bus.DFO_valid), 64'd1);
        check("t4_rs", 64'(bus.DFO_PD_rs), 64'h55);
        check("t4_pc", 64'(bus.DFO_AA_pc), 64'h400);
        check("t4_count", 64'(count), 64'd6);
        step();
        check("t4_hold_valid", 64'(bus.DFO_valid), 64'd1);
        check("t4_hold_pc", 64'(bus.DFO_AA_pc), 64'h400);

        // 6: stall blocks issue only
        stall = 1'b1;
        bus.DFI_ready = 1'b1;
        put(32'h500, 1'b1, 5'd0);
        #1;
        check("t6_stall_valid", 64'(bus.DFO_valid), 64'd0);
        check("t6_stall_ready", 64'(bus.DFO_ready), 64'd1);
        step();
        nodisp();
        #1;
        check("t6_stall2_valid", 64'(bus.DFO_valid), 64'd0);
        check("t6_stall2_count", 64'(count), 64'd7);
        step();
        stall = 1'b0;
        #1;
        check("t6_rel_valid", 64'(bus.DFO_valid), 64'd1);
        check("t6_rel_pc", 64'(bus.DFO_AA_pc), 64'h400);
        step();
        check("t6_next_pc", 64'(bus.DFO_AA_pc), 64'h500);
        check("t6_next_rs", 64'(bus.DFO_PD_rs), 64'h1500);
        check("t6_next_count", 64'(count), 64'd6);
        step();
        check("t6_end_count", 64'(count), 64'd5);

        // 5: flush with a dispatch in the same cycle, then reset mid-stream
        clear = 1'b1;
        put(32'h600, 1'b1, 5'd0);
        #1;
        check("t5_clr_valid", 64'(bus.DFO_valid), 64'd0);
        step();
        clear = 1'b0;
        nodisp();
        #1;
        check("t5_clr_count", 64'(count), 64'd0);
        check("t5_clr_valid2", 64'(bus.DFO_valid), 64'd0);
        check("t5_clr_ready", 64'(bus.DFO_ready), 64'd1);
        bus.DFI_ready = 1'b0;
        put(32'h700, 1'b1, 5'd0);
        step();
        put(32'h704, 1'b1, 5'd0);
        #1;
        check("t5_pre_pc", 64'(bus.DFO_AA_pc), 64'h700);
        step();
        rst = 1'b1;
        put(32'h708, 1'b1, 5'd0);
        #1;
        check("t5_pre_count", 64'(count), 64'd2);
        step();
        rst = 1'b0;
        nodisp();
        bus.DFI_ready = 1'b1;
        #1;
        chk_reset_outs("t5_rst");
`ifdef RESV_PERF_EN
        check("t5_rst_occ", 64'(occ), 64'd0);
        check("t5_rst_fcyc", 64'(fcyc), 64'd0);
`endif

        // occupancy: 0,1,2,3 during fill, then 4 for ten cycles
        put(32'h800, 1'b0, 5'd20);
        step();
        put(32'h804, 1'b0, 5'd20);
        step();
        put(32'h808, 1'b0, 5'd20);
        step();
        put(32'h80C, 1'b0, 5'd20);
        step();
        nodisp();
        #1;
        check("t6p_count", 64'(count), 64'd4);
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("t6p_count10", 64'(count), 64'd4);
`ifdef RESV_PERF_EN
        check("t6p_occ", 64'(occ), 64'd46);
        check("t6p_fcyc", 64'(fcyc), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
